// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard stall/flush/freeze control for a 5-stage pipeline
// with a saturating stall-cycle counter.
module pipeline_stall_controller (
   input  logic        CLK,
   input  logic        reset,
   input  logic        LoadUseReq,
   input  logic        BranchDepEx,
   input  logic        BranchDepLoad,
   input  logic        BranchTaken,
   input  logic        MemBusy,
   input  logic        CntClr,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        Stall,
   output logic        Freeze,
   output logic        Busy,
   output logic [15:0] StallCycles
);
   typedef enum logic [1:0] {RUN, HOLD, FREEZE} stateT;
   stateT state, nextState, cur;
   logic retHold, req;
   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= RUN;
         retHold     <= 1'b0;
         StallCycles <= '0;
      end else begin
         state <= nextState;
         if (MemBusy && state != FREEZE) retHold <= state == HOLD;
         if (CntClr) StallCycles <= '0;
         else if (!PCWrite && StallCycles != 16'hFFFF) StallCycles <= StallCycles + 16'd1;
      end
   end
   // A FREEZE that just released behaves as the state it interrupted, in the same cycle.
   always_comb begin
      req         = LoadUseReq | BranchDepEx | BranchDepLoad;
      cur         = state == FREEZE ? (retHold ? HOLD : RUN) : state;
      nextState   = cur;
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      Stall       = 1'b0;
      Freeze      = 1'b0;
      Busy        = cur != RUN;
      if (reset) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         Stall       = 1'b1;
         Busy        = 1'b0;
         nextState   = RUN;
      end else if (MemBusy) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         Freeze      = 1'b1;
         Busy        = state != RUN;
         nextState   = FREEZE;
      end else if (cur == HOLD) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         Stall       = 1'b1;
         nextState   = RUN;
      end else if (req) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         Stall       = 1'b1;
         nextState   = BranchDepLoad ? HOLD : RUN;
      end else begin
         IF_ID_Flush = BranchTaken;
         nextState   = RUN;
      end
   end
endmodule
